// File: rtl/uproc_pkg.sv
// uproc_pkg: shared widths and ALU operation codes for the accumulator CPU
package uproc_pkg;

    localparam int DATA_W  = 8;
    localparam int REG_NUM = 4;

    localparam logic [2:0] ALU_LDR = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_NOT = 3'b110;
    localparam logic [2:0] ALU_DEF = 3'b111;

endpackage

// File: rtl/alu8.sv
// alu8: combinational ALU of the accumulator CPU; carry-in feeds both ADD and SUB
module alu8
    import uproc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] r,
    input  logic              cy,
    input  logic [2:0]        alu_code,
    output logic [DATA_W-1:0] res,
    output logic              c
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // 9-bit add/subtract; bit 8 of the difference is the borrow (A < R + CY)
    always_comb begin
        sum  = {1'b0, a} + {1'b0, r} + {{DATA_W{1'b0}}, cy};
        diff = {1'b0, a} - {1'b0, r} - {{DATA_W{1'b0}}, cy};
        res  = a;
        c    = cy;
        case (alu_code)
            ALU_LDR: begin res = r;              c = 1'b0;          end
            ALU_ADD: begin res = sum[DATA_W-1:0];  c = sum[DATA_W];  end
            ALU_SUB: begin res = diff[DATA_W-1:0]; c = diff[DATA_W]; end
            ALU_AND: begin res = a & r;          c = 1'b0;          end
            ALU_OR:  begin res = a | r;          c = 1'b0;          end
            ALU_XOR: begin res = a ^ r;          c = 1'b0;          end
            ALU_NOT: begin res = ~a;             c = 1'b0;          end
            default: begin res = a;              c = cy;            end
        endcase
    end

endmodule

// File: rtl/accu_datapath.sv
// accu_datapath: accumulator A, carry CY, 4-entry register file and ALU of the 8-bit CPU
module accu_datapath #(
    parameter int          DATA_W = 8,
    parameter logic [31:0] R_INIT = 32'h04020100
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [3:0]        RegAddr,
    input  logic [2:0]        ALUCode,
    input  logic              Reg_CE,
    input  logic              CY_CE,
    input  logic              A_CE,
    input  logic              nResetCY,
    output logic [DATA_W-1:0] acc_out,
    output logic              cy_out,
    output logic              zero_out
);

    import uproc_pkg::*;

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];
    logic [DATA_W-1:0] a_q, a_d, r_sel, alu_res;
    logic              cy_q, cy_d, alu_c;

    // operand R is the OR of every register selected by the one-hot address
    always_comb begin
        r_sel = '0;
        for (int i = 0; i < REG_NUM; i++) r_sel = r_sel | (RegAddr[i] ? regs_q[i] : '0);
    end

    alu8 u_alu (
        .a        (a_q),
        .r        (r_sel),
        .cy       (cy_q),
        .alu_code (ALUCode),
        .res      (alu_res),
        .c        (alu_c)
    );

    // next state from pre-edge values; carry clear outranks carry load
    always_comb begin
        a_d  = A_CE ? alu_res : a_q;
        cy_d = !nResetCY ? 1'b0 : (CY_CE ? alu_c : cy_q);
        for (int i = 0; i < REG_NUM; i++) regs_d[i] = (Reg_CE && RegAddr[i]) ? a_q : regs_q[i];
    end

    // state registers with asynchronous reset to the initial register contents
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            a_q  <= '0;
            cy_q <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= R_INIT[i*DATA_W +: DATA_W];
        end else begin
            a_q  <= a_d;
            cy_q <= cy_d;
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign acc_out  = a_q;
    assign cy_out   = cy_q;
    assign zero_out = (a_q == '0);

endmodule

// File: tb/tb_accu_datapath.sv
// tb_accu_datapath: directed checks of the accumulator datapath
module tb_accu_datapath;

    localparam logic [2:0] OP_LDR = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_DEF = 3'b111;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic [3:0] RegAddr = 4'b0000;
    logic [2:0] ALUCode = OP_DEF;
    logic       Reg_CE = 1'b0;
    logic       CY_CE = 1'b0;
    logic       A_CE = 1'b0;
    logic       nResetCY = 1'b1;
    logic [7:0] acc_out;
    logic       cy_out;
    logic       zero_out;

    int total = 0;
    int bad = 0;

    accu_datapath dut (
        .clk      (clk),
        .nReset   (nReset),
        .RegAddr  (RegAddr),
        .ALUCode  (ALUCode),
        .Reg_CE   (Reg_CE),
        .CY_CE    (CY_CE),
        .A_CE     (A_CE),
        .nResetCY (nResetCY),
        .acc_out  (acc_out),
        .cy_out   (cy_out),
        .zero_out (zero_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] ea, input logic ec);
        logic ez;
        ez = (ea == 8'd0);
        total++;
        assert (acc_out === ea && cy_out === ec && zero_out === ez)
        else begin
            bad++;
            $error("FAIL %s: acc/cy/zero=%0d/%b/%b expected %0d/%b/%b",
                   tag, acc_out, cy_out, zero_out, ea, ec, ez);
        end
    endtask

    task automatic step(input logic [3:0] addr, input logic [2:0] op, input logic rce,
                        input logic cce, input logic ace, input logic nrcy);
        RegAddr  = addr;
        ALUCode  = op;
        Reg_CE   = rce;
        CY_CE    = cce;
        A_CE     = ace;
        nResetCY = nrcy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("reset", 8'd0, 1'b0);
        nReset = 1'b1;
        step(4'b0001, OP_LDR, 0, 1, 1, 1); chk("ldr_r0_init", 8'd0, 1'b0);
        step(4'b0010, OP_LDR, 0, 1, 1, 1); chk("ldr_r1_init", 8'd1, 1'b0);
        step(4'b0100, OP_LDR, 0, 1, 1, 1); chk("ldr_r2_init", 8'd2, 1'b0);
        step(4'b1000, OP_LDR, 0, 1, 1, 1); chk("ldr_r3_init", 8'd4, 1'b0);
        nReset = 1'b0;
        #2;
        chk("mid_reset_1", 8'd0, 1'b0);
        nReset = 1'b1;
        step(4'b1000, OP_ADD, 0, 1, 1, 1); chk("add_r3", 8'd4, 1'b0);
        step(4'b0100, OP_ADD, 0, 1, 1, 1); chk("add_r2", 8'd6, 1'b0);
        step(4'b0010, OP_ADD, 0, 1, 1, 1); chk("add_r1", 8'd7, 1'b0);
        step(4'b0001, OP_DEF, 1, 0, 0, 1); chk("store_r0", 8'd7, 1'b0);
        step(4'b0001, OP_SUB, 0, 1, 1, 1); chk("sub_r0", 8'd0, 1'b0);
        step(4'b0100, OP_SUB, 0, 1, 1, 1); chk("sub_r2_borrow", 8'd254, 1'b1);
        step(4'b1000, OP_SUB, 0, 1, 1, 1); chk("sub_r3_bin", 8'd249, 1'b0);
        step(4'b1000, OP_SUB, 0, 1, 1, 1); chk("sub_r3", 8'd245, 1'b0);
        step(4'b0010, OP_SUB, 0, 1, 1, 1); chk("sub_r1", 8'd244, 1'b0);
        step(4'b0000, OP_NOT, 0, 0, 1, 1); chk("not", 8'd11, 1'b0);
        step(4'b0010, OP_AND, 0, 1, 1, 1); chk("and_r1", 8'd1, 1'b0);
        step(4'b0001, OP_XOR, 0, 1, 1, 1); chk("xor_r0", 8'd6, 1'b0);
        step(4'b1000, OP_OR,  0, 1, 1, 1); chk("or_r3", 8'd6, 1'b0);
        step(4'b0000, OP_LDR, 0, 1, 1, 1); chk("ldr_none", 8'd0, 1'b0);
        step(4'b0000, OP_NOT, 0, 0, 1, 1); chk("not_ff", 8'd255, 1'b0);
        step(4'b0010, OP_ADD, 0, 1, 1, 1); chk("add_wrap", 8'd0, 1'b1);
        step(4'b0000, OP_ADD, 0, 1, 1, 0); chk("add_cin_clr", 8'd1, 1'b0);
        step(4'b0000, OP_NOT, 0, 0, 1, 1); chk("not_fe", 8'd254, 1'b0);
        step(4'b0001, OP_ADD, 0, 1, 1, 0); chk("clr_over_load", 8'd5, 1'b0);
        step(4'b0010, OP_ADD, 1, 1, 1, 1); chk("both_ce", 8'd6, 1'b0);
        step(4'b0010, OP_LDR, 0, 1, 1, 1); chk("r1_old_a", 8'd5, 1'b0);
        step(4'b1111, OP_DEF, 1, 0, 0, 1); chk("store_all", 8'd5, 1'b0);
        step(4'b0001, OP_LDR, 0, 1, 1, 1); chk("all_r0", 8'd5, 1'b0);
        step(4'b0100, OP_LDR, 0, 1, 1, 1); chk("all_r2", 8'd5, 1'b0);
        step(4'b1000, OP_LDR, 0, 1, 1, 1); chk("all_r3", 8'd5, 1'b0);
        step(4'b0001, OP_SUB, 0, 1, 1, 1); chk("sub_zero", 8'd0, 1'b0);
        step(4'b0001, OP_SUB, 0, 1, 1, 1); chk("sub_under", 8'd251, 1'b1);
        step(4'b0000, OP_DEF, 0, 1, 1, 1); chk("def_keep_cy", 8'd251, 1'b1);
        step(4'b0000, OP_NOT, 0, 0, 1, 1); chk("not_hold_cy", 8'd4, 1'b1);
        step(4'b1111, OP_DEF, 0, 0, 0, 0); chk("default_word", 8'd4, 1'b0);
        step(4'b0001, OP_LDR, 0, 1, 1, 1); chk("default_no_wr", 8'd5, 1'b0);
        nReset = 1'b0;
        #2;
        chk("mid_reset_2", 8'd0, 1'b0);
        nReset = 1'b1;
        step(4'b1000, OP_LDR, 0, 1, 1, 1); chk("r3_after_rst", 8'd4, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
